// File: rtl/sap_ucode_pkg.sv
// Shared definitions for the microcode sequencer: state encodings,
// microcode entry field offsets and the entry width helpers.
package sap_ucode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_FETCH2 = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // Entry layout is {halt, end, wait, cond_en, cond_pol, cond_sel, ctrl};
    // these offsets count upward from the bit just above cond_sel.
    localparam int FLD_POL  = 0;
    localparam int FLD_EN   = 1;
    localparam int FLD_WAIT = 2;
    localparam int FLD_END  = 3;
    localparam int FLD_HALT = 4;

    function automatic int fsw_of(input int flagw);
        return (flagw > 2) ? $clog2(flagw) : 1;
    endfunction

    function automatic int uw_of(input int cw, input int fsw);
        return cw + 5 + fsw;
    endfunction

endpackage

// File: rtl/ucode_ram.sv
// Microcode store: one write port and one asynchronous read port.
// Contents are deliberately not reset so a program survives rst.
module ucode_ram #(
    parameter int AW = 7,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(negedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/microcode_sequencer.sv
// Microcoded instruction sequencer: fetch, microstep execution with wait,
// conditional skip, end and halt, driving a registered Moore control word.
module microcode_sequencer
    import sap_ucode_pkg::*;
#(
    parameter int             OPW       = 4,
    parameter int             CW        = 18,
    parameter int             MAXSTEP   = 8,
    parameter int             FLAGW     = 2,
    parameter logic [CW-1:0]  FETCH1_CW = 18'h00048,
    parameter logic [CW-1:0]  FETCH2_CW = 18'h00112,
    localparam int            SW        = $clog2(MAXSTEP),
    localparam int            FSW       = fsw_of(FLAGW),
    localparam int            UW        = uw_of(CW, FSW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              resume,
    input  logic [OPW-1:0]    opcode,
    input  logic [FLAGW-1:0]  flags,
    input  logic              mem_rdy,
    input  logic              ucode_we,
    input  logic [OPW+SW-1:0] ucode_addr,
    input  logic [UW-1:0]     ucode_wdata,
    output logic [CW-1:0]     ctrl,
    output logic [2:0]        state_o,
    output logic [SW-1:0]     step_o,
    output logic              instr_done,
    output logic              halted
);

    localparam logic [SW-1:0] LAST_STEP = SW'(MAXSTEP - 1);

    state_e         state_q, state_d;
    logic [SW-1:0]  step_q, step_d;
    logic [OPW-1:0] op_q, op_d;
    logic [CW-1:0]  ctrl_q, ctrl_d;
    logic           done_q, done_d;
    logic           halted_q;
    logic [FSW+4:0] hdr_q;
    logic [UW-1:0]  rd_data;
    logic           flag_bit;

    // The RAM is read at the address the sequencer is about to enter, so the
    // entry for the new step is captured into ctrl_q/hdr_q on the same edge.
    ucode_ram #(
        .AW(OPW + SW),
        .DW(UW)
    ) u_ram (
        .clk   (clk),
        .we    (ucode_we),
        .waddr (ucode_addr),
        .wdata (ucode_wdata),
        .raddr ({op_d, step_d}),
        .rdata (rd_data)
    );

    always_comb begin
        flag_bit = 1'b0;
        for (int i = 0; i < FLAGW; i++) begin
            if (hdr_q[FSW-1:0] == FSW'(i)) begin
                flag_bit = flags[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH1;
            ST_FETCH1: state_d = ST_FETCH2;
            ST_FETCH2: begin
                state_d = ST_EXEC;
                op_d    = opcode;
            end
            ST_EXEC: begin
                if (hdr_q[FSW+FLD_HALT]) begin
                    state_d = ST_HALT;
                end else if (hdr_q[FSW+FLD_WAIT] && !mem_rdy) begin
                    state_d = ST_EXEC;
                end else if (hdr_q[FSW+FLD_EN] && (flag_bit != hdr_q[FSW+FLD_POL])) begin
                    state_d = ST_FETCH1;
                    done_d  = 1'b1;
                end else if (hdr_q[FSW+FLD_END] || step_q == LAST_STEP) begin
                    state_d = ST_FETCH1;
                    done_d  = 1'b1;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_HALT:   if (resume) state_d = ST_FETCH1;
            default:   state_d = ST_IDLE;
        endcase
        if (state_d != ST_EXEC) begin
            step_d = '0;
        end
    end

    always_comb begin
        ctrl_d = '0;
        unique case (state_d)
            ST_FETCH1: ctrl_d = FETCH1_CW;
            ST_FETCH2: ctrl_d = FETCH2_CW;
            ST_EXEC:   ctrl_d = rd_data[CW-1:0];
            default:   ctrl_d = '0;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            op_q     <= '0;
            ctrl_q   <= '0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
            hdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            op_q     <= op_d;
            ctrl_q   <= ctrl_d;
            done_q   <= done_d;
            halted_q <= (state_d == ST_HALT);
            hdr_q    <= rd_data[UW-1:CW];
        end
    end

    assign ctrl       = ctrl_q;
    assign state_o    = state_q;
    assign step_o     = step_q;
    assign instr_done = done_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Randomised scoreboard bench for microcode_sequencer with a behavioural
// reference model of the instruction sequencing rules.
module tb_microcode_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        resume;
    logic [3:0]  opcode;
    logic [1:0]  flags;
    logic        memRdy;
    logic        ucodeWe;
    logic [6:0]  ucodeAddr;
    logic [23:0] ucodeWdata;
    logic [17:0] ctrl;
    logic [2:0]  stateO;
    logic [2:0]  stepO;
    logic        instrDone;
    logic        halted;

    typedef struct {
        logic [17:0] ctrl;
        logic [2:0]  st;
        logic [2:0]  step;
        logic        done;
        logic        halted;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [23:0] modelMem [128];
    int          mState = 0;
    int          mStep  = 0;
    logic [3:0]  mOp    = '0;

    microcode_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .resume      (resume),
        .opcode      (opcode),
        .flags       (flags),
        .mem_rdy     (memRdy),
        .ucode_we    (ucodeWe),
        .ucode_addr  (ucodeAddr),
        .ucode_wdata (ucodeWdata),
        .ctrl        (ctrl),
        .state_o     (stateO),
        .step_o      (stepO),
        .instr_done  (instrDone),
        .halted      (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] mkEntry(input bit h, input bit e, input bit w, input bit en,
                                            input bit pol, input bit sel, input logic [17:0] c);
        return {h, e, w, en, pol, sel, c};
    endfunction

    function automatic logic [23:0] randEntry();
        return mkEntry($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                       1'($urandom), 1'($urandom), 18'($urandom));
    endfunction

    // Reference model: one active clock edge of the sequencer, described as
    // instruction-level rules; the expected post-edge outputs go to the queue.
    task automatic modelEdge(input bit r, input bit rn, input bit rs, input logic [3:0] opc,
                             input logic [1:0] fl, input bit rdy, input bit we,
                             input logic [6:0] wa, input logic [23:0] wd);
        int          nState = mState;
        int          nStep  = mStep;
        logic [3:0]  nOp    = mOp;
        bit          nDone  = 0;
        logic [23:0] ent;
        exp_t        x;
        if (r) begin
            nState = 0;
            nStep  = 0;
            nOp    = '0;
        end else begin
            case (mState)
                0: if (rn) nState = 1;
                1: nState = 2;
                2: begin nState = 3; nStep = 0; nOp = opc; end
                3: begin
                    ent = modelMem[mOp * 8 + mStep];
                    if (ent[23]) nState = 4;
                    else if (ent[21] && !rdy) nState = 3;
                    else if (ent[20] && (fl[ent[18]] != ent[19])) begin nState = 1; nDone = 1; end
                    else if (ent[22] || mStep == 7) begin nState = 1; nDone = 1; end
                    else nStep = mStep + 1;
                end
                4: if (rs) nState = 1;
                default: nState = 0;
            endcase
        end
        x.st     = 3'(nState);
        x.step   = 3'(nStep);
        x.done   = nDone;
        x.halted = (nState == 4);
        case (nState)
            1:       x.ctrl = 18'h00048;
            2:       x.ctrl = 18'h00112;
            3:       x.ctrl = modelMem[nOp * 8 + nStep][17:0];
            default: x.ctrl = '0;
        endcase
        expQ.push_back(x);
        if (we) modelMem[wa] = wd;
        mState = nState;
        mStep  = nStep;
        mOp    = nOp;
    endtask

    task automatic applyStimulus(input bit r, input bit rn, input bit rs, input logic [3:0] opc,
                                 input logic [1:0] fl, input bit rdy, input bit we,
                                 input logic [6:0] wa, input logic [23:0] wd);
        @(posedge clk);
        rst        = r;
        run        = rn;
        resume     = rs;
        opcode     = opc;
        flags      = fl;
        memRdy     = rdy;
        ucodeWe    = we;
        ucodeAddr  = wa;
        ucodeWdata = wd;
        modelEdge(r, rn, rs, opc, fl, rdy, we, wa, wd);
    endtask

    task automatic runCycles(input int n, input bit rn, input bit rs, input logic [3:0] opc,
                             input logic [1:0] fl, input bit rdy);
        repeat (n) applyStimulus(0, rn, rs, opc, fl, rdy, 0, '0, '0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                x = expQ.pop_front();
                checkOutput("ctrl", 32'(ctrl), 32'(x.ctrl));
                checkOutput("state", 32'(stateO), 32'(x.st));
                checkOutput("instr_done", 32'(instrDone), 32'(x.done));
                checkOutput("halted", 32'(halted), 32'(x.halted));
                if (x.st == 3'd3) checkOutput("step", 32'(stepO), 32'(x.step));
            end
        end
    end

    initial begin
        logic [23:0] w;
        logic [6:0]  a;
        rst = 1'b1; run = 1'b0; resume = 1'b0; opcode = '0; flags = '0;
        memRdy = 1'b1; ucodeWe = 1'b0; ucodeAddr = '0; ucodeWdata = '0;

        // Whole program is loaded while rst is held; it must survive reset.
        for (int i = 0; i < 128; i++) begin
            a = 7'(i);
            case (i)
                0:  w = mkEntry(0, 0, 0, 0, 0, 0, 18'h000C0);
                1:  w = mkEntry(0, 1, 0, 0, 0, 0, 18'h01002);
                8:  w = mkEntry(0, 0, 0, 1, 1, 1, 18'h00011);
                9:  w = mkEntry(0, 0, 0, 0, 0, 0, 18'h00084);
                10: w = mkEntry(0, 1, 0, 0, 0, 0, 18'h00085);
                16: w = mkEntry(0, 0, 1, 0, 0, 0, 18'h00200);
                17: w = mkEntry(0, 1, 0, 0, 0, 0, 18'h00201);
                24: w = mkEntry(1, 0, 0, 0, 0, 0, 18'h3FFFF);
                default: begin
                    if (i >= 32 && i < 40) w = mkEntry(0, 0, 0, 0, 0, 0, 18'(18'h00100 + i));
                    else w = randEntry();
                end
            endcase
            applyStimulus(1, 1, 1, '0, '0, 1, 1, a, w);
        end

        runCycles(2, 0, 0, 4'd0, 2'b00, 1);
        runCycles(6, 1, 0, 4'd0, 2'b00, 1);
        runCycles(2, 0, 0, 4'd1, 2'b00, 1);
        runCycles(5, 1, 0, 4'd1, 2'b00, 1);
        runCycles(7, 1, 0, 4'd1, 2'b10, 1);
        runCycles(3, 1, 0, 4'd2, 2'b00, 1);
        runCycles(4, 1, 0, 4'd2, 2'b00, 0);
        runCycles(4, 1, 0, 4'd2, 2'b00, 1);
        runCycles(8, 1, 0, 4'd3, 2'b00, 1);
        runCycles(1, 1, 1, 4'd3, 2'b00, 1);
        runCycles(6, 1, 0, 4'd3, 2'b00, 1);
        applyStimulus(1, 1, 1, 4'd3, 2'b00, 1, 0, '0, '0);
        runCycles(14, 1, 0, 4'd4, 2'b00, 1);
        runCycles(6, 1, 0, 4'd4, 2'b00, 1);
        applyStimulus(1, 1, 0, 4'd4, 2'b00, 1, 0, '0, '0);
        runCycles(2, 0, 0, 4'd4, 2'b00, 1);

        for (int c = 0; c < 3000; c++) begin
            bit r;
            bit we;
            r  = ($urandom_range(0, 59) == 0);
            we = (mState == 0 || r) && ($urandom_range(0, 3) == 0);
            applyStimulus(r, 1'($urandom), $urandom_range(0, 3) == 0, 4'($urandom),
                          2'($urandom), $urandom_range(0, 3) != 0, we,
                          7'($urandom), randEntry());
        end

        @(posedge clk);
        @(posedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 Parameter OPW, default 4, opcode width.
REQ-002 Parameter CW, default 18, control-word width.
REQ-003 Parameter MAXSTEP, default 8 (power of 2, >=2), maximum execute microsteps per instruction; SW = log2(MAXSTEP).
REQ-004 Parameter FLAGW, default 2, flag count; FSW = max(1, log2(FLAGW)).
REQ-005 Parameters FETCH1_CW, default 18'h00048, and FETCH2_CW, default 18'h00112, fixed fetch control words.
REQ-006 clk  in  1  single clock; all state updates on the falling edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 run  in  1  leave IDLE when high.
REQ-009 resume  in  1  leave HALT when high.
REQ-010 opcode  in  OPW  instruction opcode, valid in FETCH2.
REQ-011 flags  in  FLAGW  ALU flags (bit1 zero, bit0 carry at default).
REQ-012 mem_rdy  in  1  memory ready for wait-marked steps.
REQ-013 ucode_we  in  1  microcode write strobe.
REQ-014 ucode_addr  in  OPW+SW  write address {opcode, step}.
REQ-015 ucode_wdata  in  UW  entry {halt, end, wait, cond_en, cond_pol, cond_sel[FSW], ctrl[CW]}; UW = CW+5+FSW.
REQ-016 ctrl  out  CW  registered control word.
REQ-017 state_o  out  3  current state encoding; step_o  out  SW  current step.
REQ-018 instr_done  out  1  one-cycle pulse on instruction retirement; halted  out  1  high in HALT.

Function
REQ-019 States SHALL be IDLE=0, FETCH1=1, FETCH2=2, EXEC=3, HALT=4; ctrl SHALL always hold the control word of the current state/step (Moore, registered, no input-to-ctrl combinational path).
REQ-020 IDLE: ctrl=0; SHALL stay while run=0, go to FETCH1 when run=1.
REQ-021 FETCH1: ctrl=FETCH1_CW, next FETCH2; FETCH2: ctrl=FETCH2_CW, next EXEC step 0, with opcode latched into op_q on that edge.
REQ-022 EXEC: ctrl = ctrl field of entry [op_q, step]; at each edge the entry SHALL be evaluated in priority: halt -> HALT; wait and mem_rdy=0 -> hold same step; cond_en and flags[cond_sel] != cond_pol -> FETCH1 (skip); end or step==MAXSTEP-1 -> FETCH1; else step+1.
REQ-023 instr_done SHALL be high for the cycle after any EXEC->FETCH1 transition (end, forced end, or skip), else 0.
REQ-024 A satisfied condition (flags[cond_sel]==cond_pol) without end SHALL advance to step+1.
REQ-025 HALT: ctrl=0, halted=1; SHALL go to FETCH1 when resume=1, else remain.
REQ-026 cond_sel >= FLAGW SHALL read the flag as 0.
REQ-027 Microcode writes SHALL occur at the edge with ucode_we=1 in any state; a same-edge read of that address SHALL return the old entry.
REQ-028 Step counter SHALL reset to 0 on every entry to EXEC and never wrap past MAXSTEP-1.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, step 0, op_q 0, ctrl 0, instr_done 0, halted 0, from any state including mid-EXEC and HALT, and SHALL override run/resume.
REQ-030 Microcode storage SHALL NOT be cleared by rst; a ucode write in the reset cycle SHALL still take effect.

Structure
REQ-031 Package sap_ucode_pkg SHALL hold the state encodings, entry field offsets, and the UW width function.
REQ-032 Storage SHALL be a separate sub-module ucode_ram (2^(OPW+SW) x UW, one write port, one asynchronous read port); the sequencer FSM, step counter and ctrl register live in microcode_sequencer.

Verification
REQ-033 Reset, run=1 -> ctrl sequence 0, 18'h00048, 18'h00112, then entry[op][0].ctrl on consecutive edges.
REQ-034 Opcode 0 loaded with steps 0 (ctrl 18'h000C0) and 1 (ctrl 18'h01002, end) -> those words then FETCH1, instr_done pulse once.
REQ-035 Step 0 cond_en, cond_sel=1, cond_pol=1, flags=2'b00 -> FETCH1 after one EXEC cycle; flags=2'b10 -> step 1 (ctrl 18'h00084) issued.
REQ-036 Wait step with mem_rdy=0 for 3 cycles -> ctrl held 3 extra cycles, advances on the first mem_rdy=1 edge.
REQ-037 Halt entry -> ctrl=0, halted=1 indefinitely; resume=1 -> FETCH1; rst during HALT -> IDLE.
REQ-038 Opcode with no end bit in any step -> forced return after step MAXSTEP-1 (8 EXEC cycles); rst mid-EXEC -> IDLE next edge, ctrl 0.
